// File: rtl/i2c_scheduler_pkg.sv
// Shared definitions for the I2C scheduler: engine opcodes, FSM states and
// the per-step command table for register write/read descriptors.
package i2c_scheduler_pkg;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [2:0] WR_STEPS = 3'd5;
  localparam logic [2:0] RD_STEPS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic logic [1:0] step_op(input logic rw, input logic [2:0] step);
    logic [1:0] op;
    op = OP_STOP;
    if (!rw) begin
      case (step)
        3'd0:              op = OP_START;
        3'd1, 3'd2, 3'd3:  op = OP_WRITE;
        default:           op = OP_STOP;
      endcase
    end else begin
      case (step)
        3'd0, 3'd3:        op = OP_START;
        3'd1, 3'd2, 3'd4:  op = OP_WRITE;
        3'd5:              op = OP_READ;
        default:           op = OP_STOP;
      endcase
    end
    return op;
  endfunction

  function automatic logic [7:0] step_data(input logic rw, input logic [2:0] step,
                                           input logic [6:0] addr, input logic [7:0] regi,
                                           input logic [7:0] wdata);
    logic [7:0] d;
    d = 8'h00;
    case (step)
      3'd1:    d = {addr, 1'b0};
      3'd2:    d = regi;
      3'd3:    d = rw ? 8'h00 : wdata;
      3'd4:    d = rw ? {addr, 1'b1} : 8'h00;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] stop_step(input logic rw);
    return rw ? (RD_STEPS - 3'd1) : (WR_STEPS - 3'd1);
  endfunction

endpackage

// File: rtl/i2c_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or above the pointer, with wrap.
// Purely combinational; the owner keeps and advances the pointer register.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int off = N - 1; off >= 0; off--) begin
      j = int'(ptr_i) + off;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_scheduler.sv
// Shares one byte-level I2C engine between N_REQ requesters: round-robin grant,
// descriptor expansion into START/WRITE/READ/STOP, with a per-command watchdog.
module i2c_scheduler
  import i2c_scheduler_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_reg,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic [7:0]         rdata,
  output logic               busy,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_op,
  output logic [7:0]         cmd_data,
  output logic               cmd_nack,
  input  logic               rsp_valid,
  input  logic [7:0]         rsp_data,
  input  logic               rsp_nack
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic [IW-1:0]    ptr_q, gnt_q;
  logic [N_REQ-1:0] gnt_oh_q;
  logic             rw_q, err_flag_q;
  logic [6:0]       addr_q;
  logic [7:0]       reg_q, wdata_q, rd_q;
  logic [2:0]       step_q;
  logic [TW-1:0]    wdog_q;

  logic [N_REQ-1:0] done_q;
  logic             err_q, busy_q, cmd_valid_q, cmd_nack_q;
  logic [7:0]       rdata_q, cmd_data_q;
  logic [1:0]       cmd_op_q;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  logic [1:0] cur_op, nxt_op;
  logic [2:0] step_d;
  logic [6:0] sel_addr;
  logic [7:0] sel_reg, sel_wdata;
  logic       accept, wdog_hit, go_done;

  always_comb begin
    sel_addr  = req_addr[7*int'(arb_idx) +: 7];
    sel_reg   = req_reg[8*int'(arb_idx) +: 8];
    sel_wdata = req_wdata[8*int'(arb_idx) +: 8];
    cur_op    = step_op(rw_q, step_q);
    accept    = cmd_valid_q & cmd_ready;
    wdog_hit  = (wdog_q == TW'(TIMEOUT - 1)) &&
                ((state_q == ST_ISSUE && !accept) || (state_q == ST_WAIT && !rsp_valid));
    go_done   = (cur_op == OP_STOP) && (wdog_hit || (state_q == ST_WAIT && rsp_valid));
    // A slave NACK or a stalled engine skips straight to the closing STOP.
    step_d    = step_q + 3'd1;
    if (wdog_hit || (state_q == ST_WAIT && cur_op == OP_WRITE && rsp_nack))
      step_d = stop_step(rw_q);
    nxt_op    = step_op(rw_q, step_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_oh_q    <= '0;
      rw_q        <= 1'b0;
      err_flag_q  <= 1'b0;
      addr_q      <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      step_q      <= '0;
      wdog_q      <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_START;
      cmd_data_q  <= '0;
      cmd_nack_q  <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_q       <= arb_idx;
            gnt_oh_q    <= arb_grant;
            rw_q        <= req_rw[arb_idx];
            addr_q      <= sel_addr;
            reg_q       <= sel_reg;
            wdata_q     <= sel_wdata;
            step_q      <= '0;
            err_flag_q  <= 1'b0;
            wdog_q      <= '0;
            busy_q      <= 1'b1;
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OP_START;
            cmd_data_q  <= '0;
            cmd_nack_q  <= 1'b0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (state_q == ST_ISSUE && accept) begin
            cmd_valid_q <= 1'b0;
            wdog_q      <= '0;
            state_q     <= ST_WAIT;
          end else if (go_done) begin
            cmd_valid_q <= 1'b0;
            done_q      <= gnt_oh_q;
            err_q       <= err_flag_q | wdog_hit;
            if (rw_q) rdata_q <= rd_q;
            state_q     <= ST_DONE;
          end else if (wdog_hit || (state_q == ST_WAIT && rsp_valid)) begin
            if (wdog_hit || (cur_op == OP_WRITE && rsp_nack)) err_flag_q <= 1'b1;
            if (!wdog_hit && cur_op == OP_READ) rd_q <= rsp_data;
            step_q      <= step_d;
            wdog_q      <= '0;
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= nxt_op;
            cmd_data_q  <= step_data(rw_q, step_d, addr_q, reg_q, wdata_q);
            cmd_nack_q  <= (nxt_op == OP_READ);
            state_q     <= ST_ISSUE;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          ptr_q   <= (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + IW'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_nack  = cmd_nack_q;

endmodule

// File: tb/tb_i2c_scheduler.sv
// Bench for i2c_scheduler: an engine model drives cmd_ready/rsp, directed
// descriptors push expected commands and done results into scoreboard queues.
module tb_i2c_scheduler;
  import i2c_scheduler_pkg::*;

  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk, rst;
  logic [N-1:0]   req, req_rw;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_reg, req_wdata;
  logic [N-1:0]   done;
  logic           err, busy, cmd_valid, cmd_ready, cmd_nack, rsp_valid, rsp_nack;
  logic [7:0]     rdata, cmd_data, rsp_data;
  logic [1:0]     cmd_op;

  i2c_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_reg(req_reg), .req_wdata(req_wdata), .done(done), .err(err),
    .rdata(rdata), .busy(busy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack)
  );

  int n_total, n_pass, cyc, done_cnt;
  int n_cmd, nack_at, silent_from, stall_left, stall_after;
  int last_acc_cyc, prev_acc_cyc, last_done_cyc;
  logic [7:0]  read_byte, exp_rdata;
  logic        seen_read, chk_busy_low, acc;
  logic [1:0]  acc_op;
  logic [10:0] cmd_exp[$];
  logic [11:0] done_exp[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got 0x%0h expected none (t=%0t)", name, act, $time);
  endtask

  task automatic exp_cmd(input logic [1:0] op, input logic [7:0] d);
    cmd_exp.push_back({(op == OP_READ), op, d});
  endtask

  task automatic exp_write(input logic [6:0] a, input logic [7:0] r, input logic [7:0] w);
    exp_cmd(OP_START, 8'h00);
    exp_cmd(OP_WRITE, {a, 1'b0});
    exp_cmd(OP_WRITE, r);
    exp_cmd(OP_WRITE, w);
    exp_cmd(OP_STOP, 8'h00);
  endtask

  task automatic exp_read_head(input logic [6:0] a, input logic [7:0] r);
    exp_cmd(OP_START, 8'h00);
    exp_cmd(OP_WRITE, {a, 1'b0});
    exp_cmd(OP_WRITE, r);
    exp_cmd(OP_START, 8'h00);
    exp_cmd(OP_WRITE, {a, 1'b1});
    exp_cmd(OP_READ, 8'h00);
  endtask

  task automatic exp_done(input logic [N-1:0] vec, input logic e, input logic [7:0] rd);
    done_exp.push_back({vec, e, rd});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_desc(input int i, input logic rw, input logic [6:0] a,
                          input logic [7:0] r, input logic [7:0] w);
    req_rw[i]          = rw;
    req_addr[7*i +: 7] = a;
    req_reg[8*i +: 8]  = r;
    req_wdata[8*i +: 8] = w;
  endtask

  task automatic run(input logic [N-1:0] mask, input int ndone, input int budget);
    int target;
    int k;
    target = done_cnt + ndone;
    k = 0;
    req = mask;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) fail_now("done_wait_expired", 32'(done_cnt));
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- engine model ----------------
  initial begin : engine
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    acc = 1'b0; acc_op = OP_START;
    forever begin
      @(posedge clk);
      #1;
      rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
      if (rst) begin
        acc = 1'b0;
        cmd_ready = 1'b0;
      end else begin
        if (acc) begin
          acc = 1'b0;
          n_cmd++;
          if (silent_from == 0 || n_cmd < silent_from) begin
            rsp_valid = 1'b1;
            rsp_nack  = (acc_op == OP_WRITE) && (n_cmd == nack_at);
            rsp_data  = (acc_op == OP_READ) ? read_byte : 8'h00;
          end
        end
        if (cmd_valid && stall_left > 0 && n_cmd == stall_after) begin
          cmd_ready = 1'b0;
          stall_left--;
        end else begin
          cmd_ready = cmd_valid;
          if (cmd_valid) begin
            acc = 1'b1;
            acc_op = cmd_op;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (chk_busy_low) begin
        check("busy_after_done", 32'(busy), 32'd0);
        chk_busy_low = 1'b0;
      end
      if (cmd_valid && !cmd_ready && cmd_exp.size() > 0)
        check("cmd_hold_while_stalled", 32'({cmd_nack, cmd_op, cmd_data}), 32'(cmd_exp[0]));
      if (cmd_valid && cmd_ready) begin
        if (cmd_exp.size() == 0) fail_now("cmd_unexpected", 32'({cmd_nack, cmd_op, cmd_data}));
        else check("cmd_nack_op_data", 32'({cmd_nack, cmd_op, cmd_data}), 32'(cmd_exp.pop_front()));
        check("busy_during_cmd", 32'(busy), 32'd1);
        prev_acc_cyc = last_acc_cyc;
        last_acc_cyc = cyc + 1;
        if (cmd_op == OP_READ) seen_read = 1'b1;
      end
      if (|done) begin
        if (done_exp.size() == 0) fail_now("done_unexpected", 32'({done, err, rdata}));
        else check("done_err_rdata", 32'({done, err, rdata}), 32'(done_exp.pop_front()));
        check("busy_at_done", 32'(busy), 32'd1);
        last_done_cyc = cyc;
        done_cnt++;
        chk_busy_low = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_reg = '0; req_wdata = '0;
    n_cmd = 0; nack_at = 0; silent_from = 0; stall_left = 0; stall_after = -1;
    read_byte = 8'h00; exp_rdata = 8'h00; seen_read = 1'b0; chk_busy_low = 1'b0;
    #22;
    check("rst_done",      32'(done), 32'd0);
    check("rst_err",       32'(err), 32'd0);
    check("rst_rdata",     32'(rdata), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_op",    32'(cmd_op), 32'd0);
    check("rst_cmd_data",  32'(cmd_data), 32'd0);
    check("rst_cmd_nack",  32'(cmd_nack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single write from requester 0
    set_desc(0, 1'b0, 7'h10, 8'h05, 8'hA3);
    exp_write(7'h10, 8'h05, 8'hA3);
    exp_done(3'b001, 1'b0, exp_rdata);
    n_cmd = 0;
    run(3'b001, 1, 60);

    // single read from requester 1
    set_desc(1, 1'b1, 7'h50, 8'h00, 8'hEE);
    read_byte = 8'h5A;
    exp_read_head(7'h50, 8'h00);
    exp_cmd(OP_STOP, 8'h00);
    exp_rdata = 8'h5A;
    exp_done(3'b010, 1'b0, exp_rdata);
    n_cmd = 0;
    run(3'b010, 1, 80);

    // address NACK on requester 2: straight to STOP, error reported
    set_desc(2, 1'b0, 7'h3C, 8'h11, 8'h77);
    exp_cmd(OP_START, 8'h00);
    exp_cmd(OP_WRITE, 8'h78);
    exp_cmd(OP_STOP, 8'h00);
    exp_done(3'b100, 1'b1, exp_rdata);
    n_cmd = 0; nack_at = 2;
    run(3'b100, 1, 60);
    nack_at = 0;

    // contention: all requesters held, second command stalled 5 cycles
    set_desc(0, 1'b0, 7'h21, 8'h01, 8'h11);
    set_desc(1, 1'b0, 7'h22, 8'h02, 8'h22);
    set_desc(2, 1'b0, 7'h23, 8'h03, 8'h33);
    exp_write(7'h21, 8'h01, 8'h11);
    exp_write(7'h22, 8'h02, 8'h22);
    exp_write(7'h23, 8'h03, 8'h33);
    exp_write(7'h21, 8'h01, 8'h11);
    exp_done(3'b001, 1'b0, exp_rdata);
    exp_done(3'b010, 1'b0, exp_rdata);
    exp_done(3'b100, 1'b0, exp_rdata);
    exp_done(3'b001, 1'b0, exp_rdata);
    n_cmd = 0; stall_after = 1; stall_left = 5;
    run(3'b111, 4, 250);
    stall_after = -1;

    // timeout: engine goes silent after START
    set_desc(1, 1'b0, 7'h2A, 8'h44, 8'h55);
    exp_cmd(OP_START, 8'h00);
    exp_cmd(OP_WRITE, 8'h54);
    exp_cmd(OP_STOP, 8'h00);
    exp_done(3'b010, 1'b1, exp_rdata);
    n_cmd = 0; silent_from = 2;
    run(3'b010, 1, 120);
    check("timeout_stop_after_write", 32'(last_acc_cyc - prev_acc_cyc), 32'(TO + 1));
    check("timeout_done_after_stop",  32'(last_done_cyc - last_acc_cyc), 32'(TO));

    // reset while waiting for the READ response
    set_desc(0, 1'b1, 7'h50, 8'h07, 8'h00);
    exp_read_head(7'h50, 8'h07);
    n_cmd = 0; silent_from = 6; seen_read = 1'b0;
    req = 3'b001;
    for (int k = 0; k < 80 && !seen_read; k++) @(negedge clk);
    if (!seen_read) fail_now("read_cmd_wait_expired", 32'(n_cmd));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",      32'(busy), 32'd0);
    check("arst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("arst_cmd_op",    32'(cmd_op), 32'd0);
    check("arst_cmd_nack",  32'(cmd_nack), 32'd0);
    check("arst_rdata",     32'(rdata), 32'd0);
    check("arst_done_err",  32'({done, err}), 32'd0);
    req = '0;
    cmd_exp.delete();
    silent_from = 0; n_cmd = 0; exp_rdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // pointer restarts at 0: requester 1 ahead of requester 2
    set_desc(1, 1'b0, 7'h11, 8'h12, 8'h13);
    set_desc(2, 1'b0, 7'h31, 8'h32, 8'h33);
    exp_write(7'h11, 8'h12, 8'h13);
    exp_write(7'h31, 8'h32, 8'h33);
    exp_done(3'b010, 1'b0, exp_rdata);
    exp_done(3'b100, 1'b0, exp_rdata);
    run(3'b110, 2, 150);

    check("cmd_queue_drained",  32'(cmd_exp.size()), 32'd0);
    check("done_queue_drained", 32'(done_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
